// File: rtl/alu_execute_stage.sv
// ---------------------------------------------------------------------------
// alu_execute_stage
//
// Execute stage of a 5-stage pipeline. Selects forwarded operands, performs
// the ALU operation chosen by ALU control, and registers the result into the
// EX/MEM pipeline register. Stall and flush control that register.
//
// Supported alu_op codes:
//   0010 add
//   0110 sub
//   0000 and
//   0001 or
// Every other code is illegal: the result is forced to 0 and the entry
// cannot write a register or take a branch.
//
// Handshake: there is no valid/ready pair. The in_valid input qualifies the
// ID/EX slot. While stall is high the block ignores its inputs and holds the
// EX/MEM register. The upstream stage must hold ID/EX during that time,
// because this block does not buffer anything. flush overrides stall and
// loads a bubble. out_valid qualifies the EX/MEM slot.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid              ID/EX slot holds a real instruction
//   alu_op                4-bit operation code
//   rs1_data, rs2_data    register-file operands
//   imm                   sign-extended immediate
//   alu_src               1: operand B = imm, 0: operand B = forwarded rs2
//   fwd_a, fwd_b          forwarding select (00/11 ID/EX, 01 wb_data,
//                         10 out_result)
//   wb_data               MEM/WB write-back value
//   rd, reg_write         destination register and its write enable
//   branch                instruction is a beq
//   stall, flush          EX/MEM register hold / bubble
//   out_*                 registered EX/MEM fields
// ---------------------------------------------------------------------------
module alu_execute_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             branch,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_store_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_branch_taken,
  output logic             out_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX/MEM register
  logic             valid_q,     valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic [WIDTH-1:0] store_q,     store_d;
  logic [4:0]       rd_q,        rd_d;
  logic             reg_write_q, reg_write_d;
  logic             br_taken_q,  br_taken_d;
  logic             illegal_q,   illegal_d;

  // Combinational execute datapath
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_val;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;
  logic             alu_zero;

  // Operand selection. The EX/MEM path reads result_q directly, so a
  // dependent instruction right behind its producer needs no stall. During a
  // hold, this path keeps presenting the held result.
  always_comb begin
    op_a = rs1_data;
    case (fwd_a)
      FWD_WB:  op_a = wb_data;
      FWD_MEM: op_a = result_q;
      default: op_a = rs1_data;
    endcase

    fwd_val = rs2_data;
    case (fwd_b)
      FWD_WB:  fwd_val = wb_data;
      FWD_MEM: fwd_val = result_q;
      default: fwd_val = rs2_data;
    endcase

    op_b = alu_src ? imm : fwd_val;
  end

  // ALU. Arithmetic wraps modulo 2^WIDTH; carry and borrow are dropped.
  always_comb begin
    alu_legal = 1'b1;
    alu_res   = '0;
    case (alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      default: begin
        alu_legal = 1'b0;
        alu_res   = '0;
      end
    endcase
    alu_zero = (alu_res == '0);
  end

  // Next-state of the EX/MEM register. The priority order is:
  //   flush, then stall, then no valid input, then load.
  // Reset is handled in the register process.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    store_d     = store_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    br_taken_d  = br_taken_q;
    illegal_d   = illegal_q;

    if (flush || (!stall && !in_valid)) begin
      valid_d     = 1'b0;
      result_d    = '0;
      zero_d      = 1'b0;
      store_d     = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      br_taken_d  = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      valid_d     = 1'b1;
      result_d    = alu_res;
      zero_d      = alu_zero;
      // Store data is the forwarded rs2 value, taken before the immediate
      // mux.
      store_d     = fwd_val;
      rd_d        = rd;
      reg_write_d = reg_write & alu_legal;
      // An illegal op computes 0, so its zero flag is 1. It still must not
      // redirect fetch.
      br_taken_d  = branch & alu_zero & alu_legal;
      illegal_d   = ~alu_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      br_taken_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      br_taken_q  <= br_taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_result       = result_q;
  assign out_zero         = zero_q;
  assign out_store_data   = store_q;
  assign out_rd           = rd_q;
  assign out_reg_write    = reg_write_q;
  assign out_branch_taken = br_taken_q;
  assign out_illegal      = illegal_q;

endmodule
